// File: rtl/phase_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | phase_seq_pkg                                                              |
// | Shared constants and types for the four-phase rotation checker.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package phase_seq_pkg;

  // Patterns on {clk_270, clk_180, clk_90, clk_0}
  localparam logic [3:0] Q0_CODE = 4'b1001;
  localparam logic [3:0] Q1_CODE = 4'b0011;
  localparam logic [3:0] Q2_CODE = 4'b0110;
  localparam logic [3:0] Q3_CODE = 4'b1100;

  localparam logic [1:0] ERR_ILLEGAL = 2'd0;
  localparam logic [1:0] ERR_REVERSE = 2'd1;
  localparam logic [1:0] ERR_SKIP    = 2'd2;
  localparam logic [1:0] ERR_STALL   = 2'd3;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

endpackage : phase_seq_pkg

`default_nettype wire

// File: rtl/phase_code_decode.sv
// +----------------------------------------------------------------------------+
// | phase_code_decode                                                          |
// | Maps a synchronized 4-bit phase pattern to its quadrant and legality.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module phase_code_decode (
  input  logic [3:0] code_i,
  output logic [1:0] quad_o,
  output logic       legal_o
);
  import phase_seq_pkg::*;

  always_comb begin
    quad_o  = 2'd0;
    legal_o = 1'b0;
    case (code_i)
      Q0_CODE: begin quad_o = 2'd0; legal_o = 1'b1; end
      Q1_CODE: begin quad_o = 2'd1; legal_o = 1'b1; end
      Q2_CODE: begin quad_o = 2'd2; legal_o = 1'b1; end
      Q3_CODE: begin quad_o = 2'd3; legal_o = 1'b1; end
      default: begin quad_o = 2'd0; legal_o = 1'b0; end
    endcase
  end

endmodule : phase_code_decode

`default_nettype wire

// File: rtl/phase_seq_decoder.sv
// +----------------------------------------------------------------------------+
// | phase_seq_decoder                                                          |
// | Samples a four-phase clock set, checks forward rotation, counts rotations  |
// | and tracks lock. Stall watchdog compiled in with PHASE_SEQ_STALL_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module phase_seq_decoder #(
  parameter int LOCK_CNT  = 8,
  parameter int CNT_W     = 16,
  parameter int STALL_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       ph_in,
  input  logic             clear,
  output logic [1:0]       quadrant,
  output logic             quad_valid,
  output logic             locked,
  output logic [CNT_W-1:0] rot_count,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic             err_sticky
);
  import phase_seq_pkg::*;

  localparam int ACQ_W = $clog2(LOCK_CNT + 1);

  logic [3:0]       s1_q, s2_q;
  logic [1:0]       dec_quad;
  logic             dec_legal;

  logic [1:0]       quad_q, quad_d;
  logic             qv_q, qv_d;
  lock_state_e      state_q, state_d;
  logic [ACQ_W-1:0] acq_q, acq_d;
  logic [CNT_W-1:0] rot_q, rot_d;
  logic             ep_q, ep_d;
  logic [1:0]       ec_q, ec_d;
  logic             es_q, es_d;

  logic [1:0]       qstep;
  logic             tracking;
  logic             quad_chg;
  logic             is_fwd, is_rev, is_skip, is_ill, is_stall;
  logic             any_err;
  logic             rot_inc;

  phase_code_decode u_decode (
    .code_i  (s2_q),
    .quad_o  (dec_quad),
    .legal_o (dec_legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 4'd0;
      s2_q <= 4'd0;
    end else begin
      s1_q <= ph_in;
      s2_q <= s1_q;
    end
  end

  // Illegal codes leave quad_q untouched, so the next legal code is judged against the last good one.
  assign qstep    = dec_quad - quad_q;
  assign tracking = (state_q != ST_UNLOCKED);
  assign quad_chg = dec_legal && (qstep != 2'd0);
  assign is_fwd   = dec_legal && tracking && (qstep == 2'd1);
  assign is_rev   = dec_legal && tracking && (qstep == 2'd3);
  assign is_skip  = dec_legal && tracking && (qstep == 2'd2);
  // Reported on entry into an illegal pattern; this also hides the all-zero reset pattern.
  assign is_ill   = !dec_legal && qv_q;

`ifdef PHASE_SEQ_STALL_EN
  localparam int WD_W = $clog2(STALL_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (quad_chg) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(STALL_CYC)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign is_stall = tracking && !quad_chg && (wd_q == WD_W'(STALL_CYC - 1));
`else
  logic stall_cfg_unused;
  assign stall_cfg_unused = (STALL_CYC > 0);
  assign is_stall         = 1'b0;
`endif

  assign any_err = is_ill || is_skip || is_rev || is_stall;

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    quad_d  = quad_q;
    qv_d    = dec_legal;
    ep_d    = any_err;
    ec_d    = ec_q;
    rot_inc = 1'b0;

    if (dec_legal) begin
      quad_d = dec_quad;
    end

    if (is_ill) begin
      ec_d = ERR_ILLEGAL;
    end else if (is_skip) begin
      ec_d = ERR_SKIP;
    end else if (is_rev) begin
      ec_d = ERR_REVERSE;
    end else if (is_stall) begin
      ec_d = ERR_STALL;
    end

    case (state_q)
      ST_UNLOCKED: begin
        if (dec_legal) begin
          state_d = ST_ACQUIRE;
          acq_d   = '0;
        end
      end
      ST_ACQUIRE: begin
        if (is_ill || is_stall) begin
          state_d = ST_UNLOCKED;
          acq_d   = '0;
        end else if (is_skip || is_rev) begin
          acq_d = '0;
        end else if (is_fwd) begin
          if (acq_q == ACQ_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            acq_d   = '0;
            rot_inc = (quad_q == 2'd3);
          end else begin
            acq_d = acq_q + ACQ_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_d = ST_UNLOCKED;
        end else if (is_fwd && (quad_q == 2'd3)) begin
          rot_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        acq_d   = '0;
      end
    endcase

    // clear beats a same-cycle increment; a same-cycle error beats clear on the sticky flag.
    rot_d = rot_q;
    if (clear) begin
      rot_d = '0;
    end else if (rot_inc) begin
      rot_d = rot_q + CNT_W'(1);
    end

    es_d = es_q;
    if (any_err) begin
      es_d = 1'b1;
    end else if (clear) begin
      es_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_UNLOCKED;
      acq_q   <= '0;
      quad_q  <= 2'd0;
      qv_q    <= 1'b0;
      rot_q   <= '0;
      ep_q    <= 1'b0;
      ec_q    <= 2'd0;
      es_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      quad_q  <= quad_d;
      qv_q    <= qv_d;
      rot_q   <= rot_d;
      ep_q    <= ep_d;
      ec_q    <= ec_d;
      es_q    <= es_d;
    end
  end

  assign quadrant   = quad_q;
  assign quad_valid = qv_q;
  assign locked     = (state_q == ST_LOCKED);
  assign rot_count  = rot_q;
  assign err_pulse  = ep_q;
  assign err_code   = ec_q;
  assign err_sticky = es_q;

endmodule : phase_seq_decoder

`default_nettype wire

// File: tb/tb_phase_seq_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_phase_seq_decoder                                                       |
// | Scoreboard bench: lock, rotation count/wrap, errors, clear, stall, reset.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_phase_seq_decoder;
  import phase_seq_pkg::*;

  localparam int LOCK_CNT  = 8;
  localparam int CNT_W     = 4;
  localparam int STALL_CYC = 64;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       ph_in = 4'd0;
  logic             clear = 1'b0;
  logic [1:0]       quadrant;
  logic             quad_valid;
  logic             locked;
  logic [CNT_W-1:0] rot_count;
  logic             err_pulse;
  logic [1:0]       err_code;
  logic             err_sticky;

  typedef struct packed {
    logic [1:0]       quad;
    logic             qv;
    logic             lk;
    logic [CNT_W-1:0] rot;
    logic             ep;
    logic [1:0]       ec;
    logic             es;
  } snap_t;

  snap_t exp_q[$];
  int    n_pass = 0;
  int    n_chk  = 0;

  always #5 clk = ~clk;

  phase_seq_decoder #(
    .LOCK_CNT  (LOCK_CNT),
    .CNT_W     (CNT_W),
    .STALL_CYC (STALL_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ph_in      (ph_in),
    .clear      (clear),
    .quadrant   (quadrant),
    .quad_valid (quad_valid),
    .locked     (locked),
    .rot_count  (rot_count),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_sticky (err_sticky)
  );

  function automatic snap_t observe();
    snap_t s;
    s.quad = quadrant;  s.qv = quad_valid; s.lk = locked; s.rot = rot_count;
    s.ep   = err_pulse; s.ec = err_code;   s.es = err_sticky;
    return s;
  endfunction

  function automatic snap_t mk(input int q, input bit qv, input bit lk, input int rot,
                               input bit ep, input logic [1:0] ec, input bit es);
    snap_t s;
    s.quad = 2'(q); s.qv = qv; s.lk = lk; s.rot = CNT_W'(rot);
    s.ep   = ep;    s.ec = ec; s.es = es;
    return s;
  endfunction

  function automatic logic [3:0] code_of(input int q);
    case (q % 4)
      0:       return Q0_CODE;
      1:       return Q1_CODE;
      2:       return Q2_CODE;
      default: return Q3_CODE;
    endcase
  endfunction

  // Entered just after a falling edge; holds the code for 4 cycles. 'first' is the
  // cycle the code reaches the outputs, 'last' the final cycle of the hold.
  task automatic step(input logic [3:0] code, input bit clr, output snap_t first, output snap_t last);
    ph_in = code;
    @(negedge clk);
    @(negedge clk);
    if (clr) clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    first = observe();
    @(negedge clk);
    last = observe();
  endtask

  task automatic test_reset();
    snap_t got, want, last;
    reset_n = 1'b0;
    ph_in   = 4'd0;
    repeat (3) @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0));
    got = observe(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL reset_state: got %b want %b", got, want); else n_pass++;
    reset_n = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0));
    step(4'b0000, 1'b0, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (last !== want) $display("FAIL reset_zero_code_silent: got %b want %b", last, want); else n_pass++;
  endtask

  task automatic test_lock();
    snap_t got, want, last;
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(mk(k % 4, 1, k >= LOCK_CNT, (k >= LOCK_CNT) ? 1 : 0, 0, 2'd0, 0));
      step(code_of(k), 1'b0, got, last);
      want = exp_q.pop_front(); n_chk++;
      if (got !== want) $display("FAIL lock step %0d: got %b want %b", k, got, want); else n_pass++;
    end
  endtask

  task automatic test_reverse();
    snap_t got, want, last;
    exp_q.push_back(mk(0, 1, 0, 1, 1, ERR_REVERSE, 1));
    exp_q.push_back(mk(0, 1, 0, 1, 0, ERR_REVERSE, 1));
    step(Q0_CODE, 1'b0, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL reverse_err: got %b want %b", got, want); else n_pass++;
    want = exp_q.pop_front(); n_chk++;
    if (last !== want) $display("FAIL reverse_pulse_width: got %b want %b", last, want); else n_pass++;
  endtask

  task automatic test_skip_illegal();
    snap_t got, want, last;
    exp_q.push_back(mk(2, 1, 0, 1, 1, ERR_SKIP, 1));
    step(Q2_CODE, 1'b0, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL skip_err: got %b want %b", got, want); else n_pass++;
    exp_q.push_back(mk(2, 0, 0, 1, 1, ERR_ILLEGAL, 1));
    exp_q.push_back(mk(2, 0, 0, 1, 0, ERR_ILLEGAL, 1));
    step(4'b1111, 1'b0, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL illegal_err: got %b want %b", got, want); else n_pass++;
    want = exp_q.pop_front(); n_chk++;
    if (last !== want) $display("FAIL illegal_hold: got %b want %b", last, want); else n_pass++;
  endtask

  task automatic test_wrap_clear();
    snap_t got, want, last;
    int    rot;
    exp_q.push_back(mk(2, 0, 0, 0, 0, ERR_ILLEGAL, 0));
    step(4'b1111, 1'b1, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL clear_counts: got %b want %b", got, want); else n_pass++;
    rot = 0;
    for (int k = 0; k <= 72; k++) begin
      if (k >= LOCK_CNT && (k % 4) == 0) rot = (rot + 1) % (1 << CNT_W);
      if (k == 72) rot = 0;
      exp_q.push_back(mk(k % 4, 1, k >= LOCK_CNT, rot, 0, ERR_ILLEGAL, 0));
      step(code_of(k), k == 72, got, last);
      want = exp_q.pop_front(); n_chk++;
      if (got !== want) $display("FAIL wrap step %0d: got %b want %b", k, got, want); else n_pass++;
    end
  endtask

  task automatic test_stall();
    snap_t got, want, last;
    int    hit;
    logic [1:0] hit_ec;
    logic  hit_lk;
    exp_q.push_back(mk(1, 1, 1, 0, 0, ERR_ILLEGAL, 0));
    step(Q1_CODE, 1'b0, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL stall_setup: got %b want %b", got, want); else n_pass++;
    hit = -1; hit_ec = 2'd0; hit_lk = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (err_pulse === 1'b1 && hit < 0) begin
        hit = i; hit_ec = err_code; hit_lk = locked;
      end
    end
`ifdef PHASE_SEQ_STALL_EN
    n_chk++;
    if (hit !== 63 || hit_ec !== ERR_STALL || hit_lk !== 1'b0)
      $display("FAIL stall_err: got cycle %0d code %0d locked %b want cycle 63 code 3 locked 0", hit, hit_ec, hit_lk);
    else n_pass++;
`else
    exp_q.push_back(mk(1, 1, 1, 0, 0, ERR_ILLEGAL, 0));
    got = observe(); want = exp_q.pop_front(); n_chk++;
    if (hit !== -1 || got !== want)
      $display("FAIL no_stall: got first err cycle %0d state %b want none %b", hit, got, want);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    snap_t got, want, last;
    step(Q2_CODE, 1'b0, got, last);
    ph_in = Q3_CODE;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 0));
    got = observe(); want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL async_reset: got %b want %b", got, want); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(mk(3, 1, 0, 0, 0, 2'd0, 0));
    step(Q3_CODE, 1'b0, got, last);
    want = exp_q.pop_front(); n_chk++;
    if (got !== want) $display("FAIL reacq_start: got %b want %b", got, want); else n_pass++;
    for (int k = 1; k <= LOCK_CNT; k++) begin
      exp_q.push_back(mk((3 + k) % 4, 1, k == LOCK_CNT, 0, 0, 2'd0, 0));
      step(code_of(3 + k), 1'b0, got, last);
      want = exp_q.pop_front(); n_chk++;
      if (got !== want) $display("FAIL relock step %0d: got %b want %b", k, got, want); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_reverse();
    test_skip_illegal();
    test_wrap_clear();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_phase_seq_decoder

`default_nettype wire

// File: doc/phase_seq_decoder.md
# phase_seq_decoder

Receive-side checker for the four-phase clock set produced by the clock phasing generator (clk_0, clk_90, clk_180, clk_270). It samples the four phases as data with a faster system clock and decodes the current quadrant. It verifies forward rotation order, counts full rotations and maintains a lock indication. Placement: in the clock-monitoring path, downstream of the phase generator, and used as a self-check in system benches.

## Interface
- LOCK_CNT, default 8: consecutive valid forward transitions required to declare lock (≥1).
- CNT_W, default 16: width of the rotation counter.
- STALL_CYC, default 64: cycles without a quadrant change before a stall error (used only when the stall feature is compiled in).
- clk, input, 1: system sampling clock; must be at least 4× faster than the phase period.
- reset_n, input, 1: asynchronous, active-low reset.
- ph_in, input, 4: {clk_270, clk_180, clk_90, clk_0}; asynchronous to clk.
- clear, input, 1: synchronous clear of rot_count and err_sticky.
- quadrant, output, 2: decoded quadrant, 0..3.
- quad_valid, output, 1: the current synchronized pattern is a legal quadrant code.
- locked, output, 1: lock FSM is in LOCKED.
- rot_count, output, CNT_W: completed forward rotations while locked; wraps.
- err_pulse, output, 1: one-cycle pulse on any detected error.
- err_code, output, 2: cause of the latest error. 0 = illegal pattern, 1 = reverse step, 2 = skip (±2), 3 = stall.
- err_sticky, output, 1: set by any error; cleared only by clear or reset.

## Operation
- Synchronizer: two flops per bit (s1, s2). Decode operates on s2.
- Legal codes on {270,180,90,0}:
  - 4'b1001 = Q0
  - 4'b0011 = Q1
  - 4'b0110 = Q2
  - 4'b1100 = Q3
  - Any other code is illegal.
- Transition classification, comparing the new s2 code with the previous registered quadrant:
  - Same quadrant: hold.
  - +1 mod 4: forward.
  - −1 mod 4: reverse error.
  - ±2: skip error.
  - Illegal code: illegal error. quadrant holds its last legal value and quad_valid=0.
- On an illegal code, the previous quadrant reference stays at the last legal value. The first legal code after an illegal one is therefore classified against that stored value.
- Lock FSM:
  - UNLOCKED → ACQUIRE on the first legal code. The acquire counter is loaded with 0.
  - ACQUIRE: each forward transition increments the counter. When the count reaches LOCK_CNT, go to LOCKED. Any error returns the FSM to ACQUIRE with the counter set to 0 (to UNLOCKED if the code is illegal).
  - LOCKED: any error → UNLOCKED.
- rot_count increments on each Q3→Q0 forward transition taken while in LOCKED (including the transition in which lock is achieved). It wraps from 2^CNT_W−1 to 0.
- clear has priority over a simultaneous increment: rot_count becomes 0 and err_sticky becomes 0. If an error occurs in the same cycle as clear, err_sticky ends at 1.
- If several error conditions hold in one cycle, err_code priority is illegal > skip > reverse > stall.

## Timing
- Reset values:
  - s1 = s2 = 0
  - quadrant = 0
  - quad_valid = 0
  - locked = 0
  - rot_count = 0
  - err_pulse = 0
  - err_code = 0
  - err_sticky = 0
  - FSM = UNLOCKED
- Latency: a ph_in change captured at edge N reaches s2 at edge N+1. quadrant, quad_valid, err_* and the FSM update at edge N+2.
- locked asserts at the edge after the LOCK_CNT-th forward transition is classified. It deasserts at the same edge that err_pulse asserts.
- The all-zero code present at reset is illegal but is not reported as an error until the FSM has left UNLOCKED once.
- Assertion of reset_n mid-operation clears all state immediately. Reacquisition requires a full LOCK_CNT sequence.

## Configuration
- PHASE_SEQ_STALL_EN defined:
  - A watchdog counter (width ceil(log2(STALL_CYC+1))) resets on every quadrant change.
  - In ACQUIRE or LOCKED, reaching STALL_CYC raises err_pulse with err_code=3 and the FSM moves to UNLOCKED.
  - The counter then holds until the next change.
- Not defined: no watchdog logic. err_code=3 is never produced, and STALL_CYC is ignored.

## Structure
- Shared package phase_seq_pkg:
  - Quadrant code constants Q0_CODE..Q3_CODE.
  - Error code constants ERR_ILLEGAL, ERR_REVERSE, ERR_SKIP, ERR_STALL.
  - FSM state enum.
- Sub-module phase_code_decode: combinational 4-bit code → {quadrant, legal}. Instantiated once.
- The synchronizer, classifier, FSM and counters live in the top level.

## Test plan
- Reset, then apply 1001→0011→0110→1100 repeated, each held 4 clk cycles, with LOCK_CNT=8. Expect:
  - locked=1 after the 8th forward step.
  - rot_count=1 after the first locked Q3→Q0.
  - err_sticky=0.
- While locked, step 0011→1001 (reverse). Expect err_pulse for 1 cycle, err_code=1, locked=0, err_sticky=1.
- Step 1001→0110 (skip). Expect err_code=2. Then inject 1111. Expect err_code=0, quad_valid=0, quadrant held at 2.
- With CNT_W=4, run 16 locked rotations. Expect rot_count to wrap 15→0. Assert clear in the same cycle as a Q3→Q0 step. Expect rot_count=0.
- With PHASE_SEQ_STALL_EN and STALL_CYC=64, hold 0011 for 70 cycles while locked. Expect err_code=3 at cycle 64 and locked=0. Without the macro, expect no error.
- Assert reset_n low mid-rotation while locked. Expect all outputs at reset values immediately and relock only after 8 further forward steps.
